// File: rtl/alu_result_tx.sv
// Formats an 8-bit unsigned ALU result as three ASCII decimal digits plus a
// terminator and streams them to a UART tx core via tx_start/tx_done_tick.
module alu_result_tx #(
    parameter int              DBIT = 8,
    parameter logic [DBIT-1:0] TERM = 8'h0A
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      result,
    input  logic            start,
    input  logic            tx_done_tick,
    output logic [DBIT-1:0] d_in,
    output logic            tx_start,
    output logic            busy,
    output logic            done_tick
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_rem, w_rem_nxt;
    logic [1:0]      r_h, w_h_nxt;
    logic [3:0]      r_t, w_t_nxt;
    logic [1:0]      r_idx, w_idx_nxt;
    logic [DBIT-1:0] r_d_in, w_d_in_nxt;
    logic            r_tx_start, w_tx_start_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done_tick, w_done_tick_nxt;

    function automatic logic [DBIT-1:0] char_of(
        input logic [1:0] idx,
        input logic [1:0] h,
        input logic [3:0] t,
        input logic [7:0] rem
    );
        logic [7:0] digit;
        case (idx)
            2'd0:    digit = {6'd0, h};
            2'd1:    digit = {4'd0, t};
            default: digit = rem;
        endcase
        if (idx == 2'd3)
            char_of = TERM;
        else
            char_of = DBIT'(8'h30 + digit);
    endfunction

    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        w_h_nxt         = r_h;
        w_t_nxt         = r_t;
        w_idx_nxt       = r_idx;
        w_d_in_nxt      = r_d_in;
        w_tx_start_nxt  = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_tick_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                // The done_tick cycle is already IDLE but must not accept a new request.
                if (start && !r_done_tick) begin
                    w_rem_nxt   = result;
                    w_h_nxt     = 2'd0;
                    w_t_nxt     = 4'd0;
                    w_idx_nxt   = 2'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                if (r_rem >= 8'd100) begin
                    w_rem_nxt = r_rem - 8'd100;
                    w_h_nxt   = r_h + 2'd1;
                end else if (r_rem >= 8'd10) begin
                    w_rem_nxt = r_rem - 8'd10;
                    w_t_nxt   = r_t + 4'd1;
                end else begin
                    w_d_in_nxt     = char_of(2'd0, r_h, r_t, r_rem);
                    w_tx_start_nxt = 1'b1;
                    w_state_nxt    = SEND;
                end
            end
            SEND: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    if (r_idx == 2'd3) begin
                        w_done_tick_nxt = 1'b1;
                        w_busy_nxt      = 1'b0;
                        w_state_nxt     = IDLE;
                    end else begin
                        w_idx_nxt      = r_idx + 2'd1;
                        w_d_in_nxt     = char_of(r_idx + 2'd1, r_h, r_t, r_rem);
                        w_tx_start_nxt = 1'b1;
                        w_state_nxt    = SEND;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rem       <= 8'd0;
            r_h         <= 2'd0;
            r_t         <= 4'd0;
            r_idx       <= 2'd0;
            r_d_in      <= '0;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_done_tick <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_h         <= w_h_nxt;
            r_t         <= w_t_nxt;
            r_idx       <= w_idx_nxt;
            r_d_in      <= w_d_in_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_busy      <= w_busy_nxt;
            r_done_tick <= w_done_tick_nxt;
        end
    end

    assign d_in      = r_d_in;
    assign tx_start  = r_tx_start;
    assign busy      = r_busy;
    assign done_tick = r_done_tick;

endmodule

// File: tb/tb_alu_result_tx.sv
// Scoreboard bench for alu_result_tx: directed sends with a 10-cycle UART tx model.
module tb_alu_result_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] result;
    logic       start;
    logic       mdl_tick = 1'b0;
    logic       spur = 1'b0;
    wire        tx_done_tick;
    wire  [7:0] d_in;
    wire        tx_start;
    wire        busy;
    wire        done_tick;

    assign tx_done_tick = mdl_tick | spur;

    alu_result_tx #(.DBIT(8), .TERM(8'h0A)) dut (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .start        (start),
        .tx_done_tick (tx_done_tick),
        .d_in         (d_in),
        .tx_start     (tx_start),
        .busy         (busy),
        .done_tick    (done_tick)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         n_txs = 0;
    logic [7:0] exp_q[$];
    int         done_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream built from integer division, independent of the DUT's subtraction.
    task automatic push_exp(input int v);
        exp_q.push_back(8'(8'h30 + v / 100));
        exp_q.push_back(8'(8'h30 + (v / 10) % 10));
        exp_q.push_back(8'(8'h30 + v % 10));
        exp_q.push_back(8'h0A);
        done_q.push_back(v);
    endtask

    // UART tx core model: byte time of 10 cycles after each tx_start.
    initial forever begin
        @(negedge clk);
        if (tx_start === 1'b1) begin
            repeat (10) @(posedge clk);
            #1 mdl_tick = 1'b1;
            @(posedge clk);
            #1 mdl_tick = 1'b0;
        end
    end

    // Monitor: every tx_start and done_tick is matched against the scoreboard.
    initial forever begin
        logic [7:0] e;
        @(negedge clk);
        if (tx_start === 1'b1) begin
            n_txs++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_tx_start: got d_in=%0h expected no byte", d_in);
            end else begin
                e = exp_q.pop_front();
                chk("d_in_byte", {24'd0, d_in}, {24'd0, e});
            end
        end
        if (done_tick === 1'b1) begin
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL extra_done_tick: got done_tick=1 expected 0");
            end else begin
                void'(done_q.pop_front());
            end
        end
    end

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_tick !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, {31'd0, done_tick}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_txs(input int target);
        int n = 0;
        while (n_txs < target && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_send(input logic [7:0] v, input int conv, input string tag);
        int n = 0;
        push_exp(int'(v));
        @(negedge clk);
        start  = 1'b1;
        result = v;
        @(negedge clk);
        start  = 1'b0;
        result = ~v;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (tx_start !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, conv);
        wait_done(tag);
    endtask

    initial begin
        int n0;
        reset  = 1'b1;
        start  = 1'b0;
        result = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d_in", {24'd0, d_in}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done_tick", {31'd0, done_tick}, 32'd0);
        reset = 1'b0;

        run_send(8'd123, 4, "r123");
        run_send(8'd0, 1, "r0");
        run_send(8'd255, 8, "r255");

        // Starts with value 9 during CONV and WAIT of a 42 send must be ignored.
        push_exp(42);
        @(negedge clk);
        start  = 1'b1;
        result = 8'd42;
        @(negedge clk);
        start  = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        result = 8'd9;
        @(negedge clk);
        start  = 1'b0;
        wait_txs(n_txs + 2);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("r42");
        push_exp(9);
        start  = 1'b1;
        result = 8'd9;
        @(negedge clk);
        chk("start_on_done_ignored", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("start_after_done_taken", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done("r9");

        // Reset while waiting on the second digit.
        push_exp(150);
        n0 = n_txs;
        @(negedge clk);
        start  = 1'b1;
        result = 8'd150;
        @(negedge clk);
        start = 1'b0;
        wait_txs(n0 + 2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("midrst_d_in", {24'd0, d_in}, 32'd0);
        exp_q.delete();
        done_q.delete();
        n0 = n_txs;
        repeat (25) @(negedge clk);
        chk("midrst_no_more_tx", n_txs, n0);
        run_send(8'd7, 1, "r7");

        // Spurious ticks in IDLE and in the SEND cycle.
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("idle_tick_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("idle_tick_no_tx", {31'd0, tx_start}, 32'd0);
        push_exp(200);
        start  = 1'b1;
        result = 8'd200;
        @(negedge clk);
        start = 1'b0;
        n0 = 0;
        while (tx_start !== 1'b1 && n0 < 64) begin
            @(negedge clk);
            n0++;
        end
        chk("r200_latency", n0, 3);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        wait_done("r200");

        repeat (3) @(negedge clk);
        chk("bytes_drained", exp_q.size(), 0);
        chk("dones_drained", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
